// File: rtl/fb_write_arbiter_pkg.sv
// Shared frame-buffer types and constants for the write arbiter slice.
// Address/pixel widths, default frame size and the write FSM encoding.
package fb_pkg;

    localparam int FB_ADDR_W = 19;
    localparam int FB_PIX_W  = 24;
    localparam int FB_MAX    = 640 * 480;

    typedef logic [FB_ADDR_W-1:0] fb_addr_t;
    typedef logic [FB_PIX_W-1:0]  fb_pixel_t;

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        DONE
    } fb_wr_state_e;

    function automatic fb_addr_t fb_last(int w, int h);
        return fb_addr_t'(w * h - 1);
    endfunction

endpackage

// File: rtl/fb_write_arbiter_if.sv
// Requester, clear-control and RAM write-port bundle of the arbiter.
// master = draw-engine side, slave = arbiter side.
interface fb_write_arbiter_if #(
    parameter int NUM_REQ = 3
);

    logic [NUM_REQ-1:0] req_valid;
    logic [NUM_REQ-1:0] req_ready;
    fb_pkg::fb_addr_t   req_addr [NUM_REQ];
    fb_pkg::fb_pixel_t  req_data [NUM_REQ];

    logic               clear_start;
    fb_pkg::fb_pixel_t  clear_color;
    logic               clear_busy;
    logic               clear_done;

    logic               wr_en;
    fb_pkg::fb_addr_t   wr_addr;
    fb_pkg::fb_pixel_t  wr_data;
    logic               oob_err;

    modport master (
        output req_valid, req_addr, req_data,
        output clear_start, clear_color,
        input  req_ready, clear_busy, clear_done,
        input  wr_en, wr_addr, wr_data, oob_err
    );

    modport slave (
        input  req_valid, req_addr, req_data,
        input  clear_start, clear_color,
        output req_ready, clear_busy, clear_done,
        output wr_en, wr_addr, wr_data, oob_err
    );

endinterface

// File: rtl/fb_write_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first request at or after
// the pointer; the pointer advances past the winner on every grant.
module fb_rr_arbiter #(
    parameter int NUM_REQ = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en_i,
    input  logic [NUM_REQ-1:0] req_i,
    output logic [NUM_REQ-1:0] gnt_o
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [PTR_W:0] N_L = (PTR_W+1)'(NUM_REQ);

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;
    logic [PTR_W-1:0] idx;
    logic [PTR_W:0]   sum;
    logic             found;

    always_comb begin
        gnt_o = '0;
        ptr_d = ptr_q;
        found = 1'b0;
        sum   = '0;
        idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, ptr_q} + (PTR_W+1)'(k);
            if (sum >= N_L) begin
                sum = sum - N_L;
            end
            idx = sum[PTR_W-1:0];
            if (en_i && !found && req_i[idx]) begin
                found      = 1'b1;
                gnt_o[idx] = 1'b1;
                if ({1'b0, idx} == N_L - 1'b1) begin
                    ptr_d = '0;
                end else begin
                    ptr_d = idx + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= '0;
        end else if (found) begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/fb_write_arbiter.sv
// Frame-buffer write-port arbiter with full-frame clear sequencer.
// Define FB_WRITE_STATS_EN to add per-requester grant_count counters.
module fb_write_arbiter
    import fb_pkg::*;
#(
    parameter int NUM_REQ       = 3,
    parameter int SCREEN_WIDTH  = 640,
    parameter int SCREEN_HEIGHT = 480
) (
    input  logic                sys_clk,
    input  logic                reset,
`ifdef FB_WRITE_STATS_EN
    output logic [31:0]         grant_count [NUM_REQ],
`endif
    fb_write_arbiter_if.slave   bus
);

    localparam fb_addr_t LAST = fb_last(SCREEN_WIDTH, SCREEN_HEIGHT);

    fb_wr_state_e       state_q;
    fb_wr_state_e       state_d;
    fb_addr_t           cnt_q;
    fb_addr_t           cnt_d;
    fb_pixel_t          color_q;
    fb_pixel_t          color_d;
    logic               wr_en_q;
    logic               wr_en_d;
    fb_addr_t           wr_addr_q;
    fb_addr_t           wr_addr_d;
    fb_pixel_t          wr_data_q;
    fb_pixel_t          wr_data_d;
    logic               oob_q;
    logic               oob_d;

    logic [NUM_REQ-1:0] gnt;
    logic               arb_en;
    fb_addr_t           sel_addr;
    fb_pixel_t          sel_data;

    assign arb_en = (state_q == IDLE);

    fb_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .clk   (sys_clk),
        .reset (reset),
        .en_i  (arb_en),
        .req_i (bus.req_valid),
        .gnt_o (gnt)
    );

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.clear_start) state_d = CLEAR;
            CLEAR:   if (cnt_q == LAST) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready  = gnt;
        bus.clear_busy = (state_q == CLEAR);
        bus.clear_done = (state_q == DONE);
    end

    // grant is one-hot, so OR-ing the masked lanes selects the winner
    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                sel_addr = sel_addr | bus.req_addr[i];
                sel_data = sel_data | bus.req_data[i];
            end
        end
    end

    always_comb begin
        cnt_d     = cnt_q;
        color_d   = color_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        oob_d     = oob_q;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (bus.clear_start) begin
                    color_d = bus.clear_color;
                end
                if (|gnt) begin
                    if (sel_addr > LAST) begin
                        oob_d = 1'b1;
                    end else begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = sel_addr;
                        wr_data_d = sel_data;
                    end
                end
            end
            CLEAR: begin
                wr_en_d   = 1'b1;
                wr_addr_d = cnt_q;
                wr_data_d = color_q;
                if (cnt_q != LAST) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            cnt_q     <= '0;
            color_q   <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            oob_q     <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            color_q   <= color_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            oob_q     <= oob_d;
        end
    end

    assign bus.wr_en   = wr_en_q;
    assign bus.wr_addr = wr_addr_q;
    assign bus.wr_data = wr_data_q;
    assign bus.oob_err = oob_q;

`ifdef FB_WRITE_STATS_EN
    logic [31:0] stat_q [NUM_REQ];

    always_ff @(posedge sys_clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (reset) begin
                stat_q[i] <= '0;
            end else if (gnt[i] && (stat_q[i] != '1)) begin
                stat_q[i] <= stat_q[i] + 1'b1;
            end
        end
    end

    assign grant_count = stat_q;
`endif

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Randomized and directed bench for fb_write_arbiter against a
// cycle-level behavioural model of the arbitration and clear rules.
module tb_fb_write_arbiter;

    localparam int N  = 3;
    localparam int W  = 64;
    localparam int H  = 32;
    localparam int FB = W * H;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    fb_write_arbiter_if #(.NUM_REQ(N)) bus ();

`ifdef FB_WRITE_STATS_EN
    logic [31:0] grant_count [N];
`endif

    fb_write_arbiter #(
        .NUM_REQ       (N),
        .SCREEN_WIDTH  (W),
        .SCREEN_HEIGHT (H)
    ) dut (
        .sys_clk     (clk),
        .reset       (reset),
`ifdef FB_WRITE_STATS_EN
        .grant_count (grant_count),
`endif
        .bus         (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // model: phase 0 = accepting requests, 1 = sweeping, 2 = sweep finished
    int          m_ptr;
    int          m_phase;
    int          m_next;
    logic [23:0] m_color;
    logic        e_wr;
    logic        e_oob;
    logic [18:0] e_addr;
    logic [23:0] e_data;
    longint      e_cnt [N];

    function automatic int m_grant();
        if (m_phase != 0) return -1;
        for (int k = 0; k < N; k++) begin
            if (bus.req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] m_ready();
        logic [N-1:0] r;
        int g;
        r = '0;
        g = m_grant();
        if (g >= 0) r[g] = 1'b1;
        return r;
    endfunction

    task automatic model_step();
        int g;
        if (reset) begin
            m_ptr = 0; m_phase = 0; m_next = 0; m_color = '0;
            e_wr = 0; e_oob = 0; e_addr = '0; e_data = '0;
            for (int i = 0; i < N; i++) e_cnt[i] = 0;
            return;
        end
        g = m_grant();
        e_wr = 0;
        case (m_phase)
            0: begin
                if (g >= 0) begin
                    e_cnt[g]++;
                    m_ptr = (g + 1) % N;
                    if (int'(bus.req_addr[g]) >= FB) begin
                        e_oob = 1;
                    end else begin
                        e_wr = 1;
                        e_addr = bus.req_addr[g];
                        e_data = bus.req_data[g];
                    end
                end
                if (bus.clear_start) begin
                    m_color = bus.clear_color;
                    m_phase = 1;
                    m_next = 0;
                end
            end
            1: begin
                e_wr = 1;
                e_addr = 19'(m_next);
                e_data = m_color;
                m_next++;
                if (m_next == FB) m_phase = 2;
            end
            default: m_phase = 0;
        endcase
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive_idle();
        bus.req_valid = '0;
        for (int i = 0; i < N; i++) begin
            bus.req_addr[i] = '0;
            bus.req_data[i] = '0;
        end
        bus.clear_start = 1'b0;
        bus.clear_color = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive_idle();
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_vec++;
        if (bus.wr_en !== 1'b0) begin
            n_err++; $display("FAIL rst_wr_en: got %b want 0", bus.wr_en);
        end
        n_vec++;
        if (bus.oob_err !== 1'b0) begin
            n_err++; $display("FAIL rst_oob: got %b want 0", bus.oob_err);
        end
        n_vec++;
        if (bus.clear_busy !== 1'b0 || bus.clear_done !== 1'b0) begin
            n_err++;
            $display("FAIL rst_clear: busy %b done %b want 0 0",
                     bus.clear_busy, bus.clear_done);
        end
        n_vec++;
        if (bus.req_ready !== 3'b000) begin
            n_err++; $display("FAIL rst_ready_idle: got %b want 000", bus.req_ready);
        end
        bus.req_valid = 3'b111;
        #1;
        n_vec++;
        if (bus.req_ready !== 3'b001) begin
            n_err++; $display("FAIL rst_ptr: got %b want 001", bus.req_ready);
        end
        drive_idle();
    endtask

    task automatic test_single();
        bus.req_valid = 3'b001;
        bus.req_addr[0] = 19'd100;
        bus.req_data[0] = 24'hFF0000;
        #1;
        n_vec++;
        if (bus.req_ready !== 3'b001) begin
            n_err++; $display("FAIL single_ready: got %b want 001", bus.req_ready);
        end
        tick();
        drive_idle();
        #1;
        n_vec++;
        if (bus.wr_en !== 1'b1 || bus.wr_addr !== 19'd100 ||
            bus.wr_data !== 24'hFF0000) begin
            n_err++;
            $display("FAIL single_wr: got en %b addr %0d data %h want 1 100 ff0000",
                     bus.wr_en, bus.wr_addr, bus.wr_data);
        end
        tick();
        #1;
        n_vec++;
        if (bus.wr_en !== 1'b0) begin
            n_err++; $display("FAIL single_quiet: got %b want 0", bus.wr_en);
        end
    endtask

    task automatic test_round_robin();
        logic [2:0] exp;
        do_reset();
        bus.req_valid = 3'b111;
        for (int i = 0; i < N; i++) begin
            bus.req_addr[i] = 19'(10 * (i + 1));
            bus.req_data[i] = 24'(32'hA0 + i);
        end
        for (int c = 0; c < 6; c++) begin
            #1;
            exp = 3'b001 << (c % 3);
            n_vec++;
            if (bus.req_ready !== exp) begin
                n_err++;
                $display("FAIL rr_grant[%0d]: got %b want %b", c, bus.req_ready, exp);
            end
            if (c > 0) begin
                n_vec++;
                if (bus.wr_en !== 1'b1 ||
                    bus.wr_addr !== 19'(10 * ((c - 1) % 3 + 1))) begin
                    n_err++;
                    $display("FAIL rr_wr[%0d]: got en %b addr %0d want 1 %0d",
                             c, bus.wr_en, bus.wr_addr, 10 * ((c - 1) % 3 + 1));
                end
            end
            tick();
        end
        drive_idle();
        #1;
        n_vec++;
        if (bus.wr_en !== 1'b1 || bus.wr_addr !== 19'd30) begin
            n_err++;
            $display("FAIL rr_last: got en %b addr %0d want 1 30", bus.wr_en, bus.wr_addr);
        end
        tick();
    endtask

    task automatic test_oob();
        bus.req_valid = 3'b010;
        bus.req_addr[1] = 19'(FB);
        bus.req_data[1] = 24'h777777;
        #1;
        n_vec++;
        if (bus.req_ready !== 3'b010) begin
            n_err++; $display("FAIL oob_ready: got %b want 010", bus.req_ready);
        end
        tick();
        drive_idle();
        #1;
        n_vec++;
        if (bus.wr_en !== 1'b0 || bus.oob_err !== 1'b1) begin
            n_err++;
            $display("FAIL oob_flag: got en %b oob %b want 0 1", bus.wr_en, bus.oob_err);
        end
        repeat (100) tick();
        #1;
        n_vec++;
        if (bus.oob_err !== 1'b1) begin
            n_err++; $display("FAIL oob_sticky: got %b want 1", bus.oob_err);
        end
        bus.req_valid = 3'b010;
        bus.req_addr[1] = 19'(FB - 1);
        bus.req_data[1] = 24'h123123;
        tick();
        drive_idle();
        #1;
        n_vec++;
        if (bus.wr_en !== 1'b1 || bus.wr_addr !== 19'(FB - 1)) begin
            n_err++;
            $display("FAIL oob_edge: got en %b addr %0d want 1 %0d",
                     bus.wr_en, bus.wr_addr, FB - 1);
        end
        tick();
    endtask

    task automatic test_clear();
        int writes, bad, done_n, ready_bad, model_bad;
        logic done_ok;
        writes = 0; bad = 0; done_n = 0; ready_bad = 0; model_bad = 0;
        done_ok = 1'b0;
        drive_idle();
        bus.clear_color = 24'h00FF00;
        bus.clear_start = 1'b1;
        tick();
        drive_idle();
        bus.req_valid = 3'b111;
        for (int i = 0; i < N; i++) bus.req_addr[i] = 19'(5 + i);
        for (int c = 0; c < FB + 8; c++) begin
            #1;
            if (m_phase != 0 && bus.req_ready !== 3'b000) ready_bad++;
            if (bus.wr_en && (bus.clear_busy || bus.clear_done)) begin
                if (bus.wr_addr !== 19'(writes) || bus.wr_data !== 24'h00FF00) bad++;
                writes++;
            end
            if (bus.clear_done) begin
                done_n++;
                if (bus.wr_en && int'(bus.wr_addr) == FB - 1) done_ok = 1'b1;
            end
            if (bus.wr_en !== e_wr || bus.clear_busy !== (m_phase == 1)) model_bad++;
            tick();
        end
        drive_idle();
        n_vec++;
        if (writes != FB) begin
            n_err++; $display("FAIL clr_count: got %0d want %0d", writes, FB);
        end
        n_vec++;
        if (bad != 0) begin
            n_err++; $display("FAIL clr_addr_data: got %0d bad want 0", bad);
        end
        n_vec++;
        if (done_n != 1 || !done_ok) begin
            n_err++;
            $display("FAIL clr_done: got %0d pulses ok %b want 1 1", done_n, done_ok);
        end
        n_vec++;
        if (ready_bad != 0) begin
            n_err++; $display("FAIL clr_ready: got %0d cycles ready want 0", ready_bad);
        end
        n_vec++;
        if (model_bad != 0) begin
            n_err++; $display("FAIL clr_model: got %0d diffs want 0", model_bad);
        end
    endtask

    task automatic test_clear_with_grant();
        int writes, bad, done_n;
        writes = 0; bad = 0; done_n = 0;
        drive_idle();
        bus.req_valid = 3'b100;
        bus.req_addr[2] = 19'd500;
        bus.req_data[2] = 24'hABCDEF;
        bus.clear_start = 1'b1;
        bus.clear_color = 24'h123456;
        #1;
        n_vec++;
        if (bus.req_ready !== 3'b100) begin
            n_err++; $display("FAIL cg_ready: got %b want 100", bus.req_ready);
        end
        tick();
        drive_idle();
        #1;
        n_vec++;
        if (bus.wr_en !== 1'b1 || bus.wr_addr !== 19'd500 ||
            bus.wr_data !== 24'hABCDEF || bus.clear_busy !== 1'b1) begin
            n_err++;
            $display("FAIL cg_first: got en %b addr %0d data %h busy %b want 1 500 abcdef 1",
                     bus.wr_en, bus.wr_addr, bus.wr_data, bus.clear_busy);
        end
        tick();
        for (int c = 0; c < FB + 8; c++) begin
            bus.clear_start = (c == 5);
            bus.clear_color = (c == 5) ? 24'h654321 : 24'h0;
            #1;
            if (bus.wr_en && (bus.clear_busy || bus.clear_done)) begin
                if (bus.wr_addr !== 19'(writes) || bus.wr_data !== 24'h123456) bad++;
                writes++;
            end
            if (bus.clear_done) done_n++;
            tick();
        end
        drive_idle();
        #1;
        n_vec++;
        if (writes != FB || bad != 0) begin
            n_err++;
            $display("FAIL cg_sweep: got %0d writes %0d bad want %0d 0", writes, bad, FB);
        end
        n_vec++;
        if (done_n != 1 || bus.clear_busy !== 1'b0) begin
            n_err++;
            $display("FAIL cg_ignored: got %0d pulses busy %b want 1 0",
                     done_n, bus.clear_busy);
        end
    endtask

    task automatic test_reset_mid_clear();
        logic found;
        int extra;
        found = 1'b0;
        extra = 0;
        drive_idle();
        bus.clear_color = 24'hABABAB;
        bus.clear_start = 1'b1;
        tick();
        drive_idle();
        for (int c = 0; c < FB + 8 && !found; c++) begin
            #1;
            if (bus.wr_en && bus.clear_busy && bus.wr_addr == 19'd1000) found = 1'b1;
            else tick();
        end
        n_vec++;
        if (!found) begin
            n_err++; $display("FAIL rc_reach: got no addr 1000 want addr 1000");
        end
        reset = 1'b1;
        tick();
        #1;
        n_vec++;
        if (bus.wr_en !== 1'b0 || bus.wr_addr !== 19'd0 || bus.wr_data !== 24'd0 ||
            bus.clear_busy !== 1'b0 || bus.clear_done !== 1'b0 || bus.oob_err !== 1'b0) begin
            n_err++;
            $display("FAIL rc_outputs: got en %b addr %0d data %h busy %b done %b oob %b want all 0",
                     bus.wr_en, bus.wr_addr, bus.wr_data,
                     bus.clear_busy, bus.clear_done, bus.oob_err);
        end
        reset = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (bus.clear_done || bus.clear_busy || bus.wr_en) extra++;
        end
        n_vec++;
        if (extra != 0) begin
            n_err++; $display("FAIL rc_quiet: got %0d active cycles want 0", extra);
        end
        bus.req_valid = 3'b001;
        bus.req_addr[0] = 19'd42;
        bus.req_data[0] = 24'h0A0B0C;
        #1;
        n_vec++;
        if (bus.req_ready !== 3'b001) begin
            n_err++; $display("FAIL rc_ready: got %b want 001", bus.req_ready);
        end
        tick();
        drive_idle();
        #1;
        n_vec++;
        if (bus.wr_en !== 1'b1 || bus.wr_addr !== 19'd42 || bus.wr_data !== 24'h0A0B0C) begin
            n_err++;
            $display("FAIL rc_serve: got en %b addr %0d data %h want 1 42 0a0b0c",
                     bus.wr_en, bus.wr_addr, bus.wr_data);
        end
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            bus.req_valid = 3'($urandom);
            for (int i = 0; i < N; i++) begin
                if ($urandom % 8 == 0) bus.req_addr[i] = 19'(FB + $urandom % 16);
                else bus.req_addr[i] = 19'($urandom % FB);
                bus.req_data[i] = 24'($urandom);
            end
            bus.clear_start = ($urandom % 700 == 0);
            bus.clear_color = 24'($urandom);
            #1;
            n_vec++;
            if (bus.req_ready !== m_ready()) begin
                n_err++;
                $display("FAIL rnd_ready[%0d]: got %b want %b", c, bus.req_ready, m_ready());
            end
            n_vec++;
            if (bus.wr_en !== e_wr) begin
                n_err++; $display("FAIL rnd_wr_en[%0d]: got %b want %b", c, bus.wr_en, e_wr);
            end
            if (e_wr) begin
                n_vec++;
                if (bus.wr_addr !== e_addr || bus.wr_data !== e_data) begin
                    n_err++;
                    $display("FAIL rnd_wr[%0d]: got %0d/%h want %0d/%h",
                             c, bus.wr_addr, bus.wr_data, e_addr, e_data);
                end
            end
            n_vec++;
            if (bus.clear_busy !== (m_phase == 1) || bus.clear_done !== (m_phase == 2)) begin
                n_err++;
                $display("FAIL rnd_clear[%0d]: got busy %b done %b want phase %0d",
                         c, bus.clear_busy, bus.clear_done, m_phase);
            end
            n_vec++;
            if (bus.oob_err !== e_oob) begin
                n_err++; $display("FAIL rnd_oob[%0d]: got %b want %b", c, bus.oob_err, e_oob);
            end
            tick();
        end
        drive_idle();
`ifdef FB_WRITE_STATS_EN
        for (int i = 0; i < N; i++) begin
            n_vec++;
            if (grant_count[i] !== 32'(e_cnt[i])) begin
                n_err++;
                $display("FAIL stats[%0d]: got %0d want %0d", i, grant_count[i], e_cnt[i]);
            end
        end
`endif
    endtask

    initial begin
        reset = 1'b1;
        drive_idle();
        test_reset();
        test_single();
        test_round_robin();
        test_oob();
        test_clear();
        test_clear_with_grant();
        test_reset_mid_clear();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
